// File: rtl/pulse_sequencer_pkg.sv
// Shared encodings for the pulse sequencer.
//   Mode field (2 bits per channel): one-shot, repeat-N, continuous; 2'b11 behaves as one-shot.
//   Channel FSM state encodings.
package pulse_sequencer_pkg;

  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeRepeatN    = 2'b01;
  localparam logic [1:0] ModeContinuous = 2'b10;

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StDelay = 2'b01;
  localparam logic [1:0] StHigh  = 2'b10;
  localparam logic [1:0] StLow   = 2'b11;

endpackage

// File: rtl/pulse_channel.sv
// One independent pulse channel: programmable delay, then pulses of programmable width/period.
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-high reset
//   start, abort           - trigger (ignored while busy) and synchronous stop (highest priority)
//   mode                   - 00 one-shot, 01 repeat-N, 10 continuous, 11 one-shot
//   delay, width, period,
//   repeat_count           - configuration, latched on an accepted start
//   pulse, busy, done      - registered outputs; done is a one-cycle completion strobe
module pulse_channel
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] width,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] repeat_count,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] One = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;       // delay / high / low phase counter
  logic [CNT_WIDTH-1:0] rem_q, rem_d;       // pulses still to emit, including the current one
  logic [CNT_WIDTH-1:0] width_q, width_d;   // clamped high length
  logic [CNT_WIDTH-1:0] low_q, low_d;       // low length, at least 1
  logic                 cont_q, cont_d;
  logic                 pulse_q, busy_q, done_q;
  logic                 done_d;

  logic [CNT_WIDTH-1:0] width_clamped;
  logic [CNT_WIDTH-1:0] low_len;
  logic [CNT_WIDTH-1:0] rep_clamped;

  always_comb begin
    width_clamped = (width == '0) ? One : width;
    // Subtract only when period exceeds the high length so nothing underflows.
    low_len       = (period > width_clamped) ? (period - width_clamped) : One;
    rep_clamped   = (repeat_count == '0) ? One : repeat_count;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    width_d = width_q;
    low_d   = low_q;
    cont_d  = cont_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cont_d  = (mode == ModeContinuous);
            rem_d   = (mode == ModeRepeatN) ? rep_clamped : One;
            width_d = width_clamped;
            low_d   = low_len;
            if (delay != '0) begin
              state_d = StDelay;
              cnt_d   = delay;
            end else begin
              state_d = StHigh;
              cnt_d   = width_clamped;
            end
          end
        end
        StDelay: begin
          if (cnt_q == One) begin
            state_d = StHigh;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - One;
          end
        end
        StHigh: begin
          if (cnt_q == One) begin
            if (!cont_q && rem_q == One) begin
              // Last pulse: no trailing low phase.
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StLow;
              cnt_d   = low_q;
              if (!cont_q) begin
                rem_d = rem_q - One;
              end
            end
          end else begin
            cnt_d = cnt_q - One;
          end
        end
        StLow: begin
          if (cnt_q == One) begin
            state_d = StHigh;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - One;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      width_q <= '0;
      low_q   <= '0;
      cont_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      width_q <= width_d;
      low_q   <= low_d;
      cont_q  <= cont_d;
      pulse_q <= (state_d == StHigh);
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Multi-channel programmable pulse generator.
// Ports:
//   clock, reset                      - rising-edge clock, asynchronous active-high reset
//   start, abort [CHANNELS]           - per-channel trigger and synchronous stop
//   mode [2*CHANNELS]                 - channel i at [2i+1:2i]
//   delay, width, period, repeat_count
//     [CHANNELS*CNT_WIDTH]            - channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   pulse, busy, done [CHANNELS]      - registered per-channel outputs
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           start,
  input  logic [CHANNELS-1:0]           abort,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS*CNT_WIDTH-1:0] delay,
  input  logic [CHANNELS*CNT_WIDTH-1:0] width,
  input  logic [CHANNELS*CNT_WIDTH-1:0] period,
  input  logic [CHANNELS*CNT_WIDTH-1:0] repeat_count,
  output logic [CHANNELS-1:0]           pulse,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_channel #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .start        (start[i]),
      .abort        (abort[i]),
      .mode         (mode[2*i +: 2]),
      .delay        (delay[i*CNT_WIDTH +: CNT_WIDTH]),
      .width        (width[i*CNT_WIDTH +: CNT_WIDTH]),
      .period       (period[i*CNT_WIDTH +: CNT_WIDTH]),
      .repeat_count (repeat_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .pulse        (pulse[i]),
      .busy         (busy[i]),
      .done         (done[i])
    );
  end

endmodule
